// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, two read ports, per-register pending-write bits.
// Latency: reads combinational (same-cycle bypass when BYPASS=1); writes and busy bits take one edge; wr_conflict registered.
// Backpressure: none; every enabled write and sb_set is accepted on the edge it is presented.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy0,
    output logic              busy1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wlive0;
    logic              wlive1;
    logic              conflict;

    // A write to r0 with the zero register enabled is discarded entirely:
    // it neither stores, bypasses, nor counts toward a port collision.
    assign wlive0   = wen0 && !(ZR && (waddr0 == '0));
    assign wlive1   = wen1 && !(ZR && (waddr1 == '0));
    assign conflict = wlive0 && wlive1 && (waddr0 == waddr1);

    // Storage array; port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wlive0) begin
                mem[waddr0] <= wdata0;
            end
            if (wlive1) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // Next scoreboard state: writebacks clear, a newly issued producer sets and overrides a clear.
    always_comb begin
        busy_d = busy_q;
        if (wen0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (wen1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    // Scoreboard bits and the collision flag, both registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wr_conflict <= conflict;
        end
    end

    // Read port 0: stored value, optionally overridden by same-cycle write data (port 1 highest).
    always_comb begin
        rdata0 = mem[raddr0];
        if (BP) begin
            if (wlive0 && (waddr0 == raddr0)) begin
                rdata0 = wdata0;
            end
            if (wlive1 && (waddr1 == raddr0)) begin
                rdata0 = wdata1;
            end
        end
        if ((ZR && (raddr0 == '0)) || !reset_n) begin
            rdata0 = '0;
        end
    end

    // Read port 1: same selection as port 0.
    always_comb begin
        rdata1 = mem[raddr1];
        if (BP) begin
            if (wlive0 && (waddr0 == raddr1)) begin
                rdata1 = wdata0;
            end
            if (wlive1 && (waddr1 == raddr1)) begin
                rdata1 = wdata1;
            end
        end
        if ((ZR && (raddr1 == '0)) || !reset_n) begin
            rdata1 = '0;
        end
    end

    // Busy bits are reported from stored state only; bit 0 never sets when r0 is hardwired.
    assign busy0 = busy_q[raddr0];
    assign busy1 = busy_q[raddr1];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wen0, wen1, sb_set;
    logic [4:0]  waddr0, waddr1, raddr0, raddr1, sb_addr;
    logic [31:0] wdata0, wdata1;

    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic        a_bs0, a_bs1, a_cf, b_bs0, b_bs1, b_cf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance A: r0 hardwired, bypass on. Instance B: plain r0, no bypass.
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(a_rd0), .rdata1(a_rd1), .busy0(a_bs0), .busy1(a_bs1),
        .sb_set(sb_set), .sb_addr(sb_addr), .wr_conflict(a_cf)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(b_rd0), .rdata1(b_rd1), .busy0(b_bs0), .busy1(b_bs1),
        .sb_set(sb_set), .sb_addr(sb_addr), .wr_conflict(b_cf)
    );

    // Reference model: cfg 0 = instance A, cfg 1 = instance B.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic        m_conf [2];

    function automatic bit is_zero_cfg(int cfg);
        return (cfg == 0);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[c][r]  = 32'h0;
                m_busy[c][r] = 1'b0;
            end
            m_conf[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(int cfg, logic [4:0] ra);
        bit z;
        logic [31:0] v;
        z = is_zero_cfg(cfg);
        if (!reset_n) return 32'h0;
        if (z && ra == 5'd0) return 32'h0;
        v = m_mem[cfg][ra];
        if (cfg == 0) begin
            if (wen0 && waddr0 == ra) v = wdata0;
            if (wen1 && waddr1 == ra) v = wdata1;
        end
        return v;
    endfunction

    function automatic logic model_busy(int cfg, logic [4:0] ra);
        if (!reset_n) return 1'b0;
        return m_busy[cfg][ra];
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit z, d0, d1;
        if (!reset_n) return;
        for (int c = 0; c < 2; c++) begin
            z  = is_zero_cfg(c);
            d0 = wen0 && !(z && waddr0 == 5'd0);
            d1 = wen1 && !(z && waddr1 == 5'd0);
            m_conf[c] = d0 && d1 && (waddr0 == waddr1);
            if (d0) m_mem[c][waddr0] = wdata0;
            if (d1) m_mem[c][waddr1] = wdata1;
            if (wen0) m_busy[c][waddr0] = 1'b0;
            if (wen1) m_busy[c][waddr1] = 1'b0;
            if (sb_set && !(z && sb_addr == 5'd0)) m_busy[c][sb_addr] = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag,
                           logic [31:0] ea0, logic [31:0] ea1, logic eab0, logic eab1, logic eac,
                           logic [31:0] eb0, logic [31:0] eb1, logic ebb0, logic ebb1, logic ebc);
        chk({tag, " A.rdata0"}, a_rd0, ea0);
        chk({tag, " A.rdata1"}, a_rd1, ea1);
        chk({tag, " A.busy0"}, {31'h0, a_bs0}, {31'h0, eab0});
        chk({tag, " A.busy1"}, {31'h0, a_bs1}, {31'h0, eab1});
        chk({tag, " A.wr_conflict"}, {31'h0, a_cf}, {31'h0, eac});
        chk({tag, " B.rdata0"}, b_rd0, eb0);
        chk({tag, " B.rdata1"}, b_rd1, eb1);
        chk({tag, " B.busy0"}, {31'h0, b_bs0}, {31'h0, ebb0});
        chk({tag, " B.busy1"}, {31'h0, b_bs1}, {31'h0, ebb1});
        chk({tag, " B.wr_conflict"}, {31'h0, b_cf}, {31'h0, ebc});
    endtask

    task automatic chk_model(string tag);
        chk_all(tag,
                model_read(0, raddr0), model_read(0, raddr1),
                model_busy(0, raddr0), model_busy(0, raddr1), reset_n && m_conf[0],
                model_read(1, raddr0), model_read(1, raddr1),
                model_busy(1, raddr0), model_busy(1, raddr1), reset_n && m_conf[1]);
    endtask

    task automatic set_in(logic w0, logic [4:0] a0, logic [31:0] d0,
                          logic w1, logic [4:0] a1, logic [31:0] d1,
                          logic [4:0] r0, logic [4:0] r1, logic s, logic [4:0] sa);
        wen0 = w0; waddr0 = a0; wdata0 = d0;
        wen1 = w1; waddr1 = a1; wdata1 = d1;
        raddr0 = r0; raddr1 = r1; sb_set = s; sb_addr = sa;
    endtask

    // Take the rising edge, update the model, return at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic w0; logic [4:0] a0; logic [31:0] d0;
        logic w1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0] r0, r1; logic s; logic [4:0] sa;
        logic [31:0] ea0, ea1; logic eab0, eab1, eac;
        logic [31:0] eb0, eb1; logic ebb0, ebb1, ebc;
    } vec_t;

    vec_t tbl [21];

    initial begin
        // Outputs are checked in the cycle the row is presented, before its edge.
        tbl[0]  = '{1,3,32'h11,   1,4,32'h22,   3,4,  0,0,  32'h11,32'h22,0,0,0,     32'h0,32'h0,0,0,0};
        tbl[1]  = '{0,0,0,        0,0,0,        3,4,  0,0,  32'h11,32'h22,0,0,0,     32'h11,32'h22,0,0,0};
        tbl[2]  = '{1,7,32'hAAAA, 1,7,32'h5555, 7,3,  0,0,  32'h5555,32'h11,0,0,0,   32'h0,32'h11,0,0,0};
        tbl[3]  = '{0,0,0,        0,0,0,        7,7,  0,0,  32'h5555,32'h5555,0,0,1, 32'h5555,32'h5555,0,0,1};
        tbl[4]  = '{0,0,0,        0,0,0,        7,4,  0,0,  32'h5555,32'h22,0,0,0,   32'h5555,32'h22,0,0,0};
        tbl[5]  = '{1,9,32'h1234, 0,0,0,        0,9,  0,0,  32'h0,32'h1234,0,0,0,    32'h0,32'h0,0,0,0};
        tbl[6]  = '{0,0,0,        0,0,0,        9,9,  0,0,  32'h1234,32'h1234,0,0,0, 32'h1234,32'h1234,0,0,0};
        tbl[7]  = '{1,0,32'hFFFF, 0,0,0,        0,0,  1,0,  32'h0,32'h0,0,0,0,       32'h0,32'h0,0,0,0};
        tbl[8]  = '{0,0,0,        0,0,0,        0,0,  0,0,  32'h0,32'h0,0,0,0,       32'hFFFF,32'hFFFF,1,1,0};
        tbl[9]  = '{0,0,0,        0,0,0,        12,12,1,12, 32'h0,32'h0,0,0,0,       32'h0,32'h0,0,0,0};
        tbl[10] = '{0,0,0,        0,0,0,        12,12,0,0,  32'h0,32'h0,1,1,0,       32'h0,32'h0,1,1,0};
        tbl[11] = '{0,0,0,        1,12,32'hBEEF,12,0, 0,0,  32'hBEEF,32'h0,1,0,0,    32'h0,32'hFFFF,1,1,0};
        tbl[12] = '{0,0,0,        0,0,0,        12,12,0,0,  32'hBEEF,32'hBEEF,0,0,0, 32'hBEEF,32'hBEEF,0,0,0};
        tbl[13] = '{1,12,32'hCAFE,0,0,0,        12,12,1,12, 32'hCAFE,32'hCAFE,0,0,0, 32'hBEEF,32'hBEEF,0,0,0};
        tbl[14] = '{0,0,0,        0,0,0,        12,12,0,0,  32'hCAFE,32'hCAFE,1,1,0, 32'hCAFE,32'hCAFE,1,1,0};
        tbl[15] = '{1,5,32'h1,    1,5,32'h2,    5,5,  0,0,  32'h2,32'h2,0,0,0,       32'h0,32'h0,0,0,0};
        tbl[16] = '{1,6,32'h3,    1,6,32'h4,    5,6,  0,0,  32'h2,32'h4,0,0,1,       32'h2,32'h0,0,0,1};
        tbl[17] = '{0,0,0,        0,0,0,        6,6,  0,0,  32'h4,32'h4,0,0,1,       32'h4,32'h4,0,0,1};
        tbl[18] = '{0,0,0,        0,0,0,        6,5,  0,0,  32'h4,32'h2,0,0,0,       32'h4,32'h2,0,0,0};
        tbl[19] = '{1,0,32'h7,    1,0,32'h8,    0,0,  0,0,  32'h0,32'h0,0,0,0,       32'hFFFF,32'hFFFF,1,1,0};
        tbl[20] = '{0,0,0,        0,0,0,        0,0,  0,0,  32'h0,32'h0,0,0,0,       32'h8,32'h8,0,0,1};

        // Power-on reset.
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        raddr0 = 5'd5; raddr1 = 5'd31;
        #1;
        chk_all("por", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].w1, tbl[i].a1, tbl[i].d1,
                   tbl[i].r0, tbl[i].r1, tbl[i].s, tbl[i].sa);
            #1;
            chk_all($sformatf("row%0d", i),
                    tbl[i].ea0, tbl[i].ea1, tbl[i].eab0, tbl[i].eab1, tbl[i].eac,
                    tbl[i].eb0, tbl[i].eb1, tbl[i].ebb0, tbl[i].ebb1, tbl[i].ebc);
            step();
        end

        // Mid-cycle asynchronous reset with r5 holding data, busy set and a conflict pending.
        set_in(1, 5, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF, 5, 5, 1, 5);
        step();
        set_in(0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
        #1;
        chk_all("pre_reset", 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1,
                             32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1);
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0BAD0BAD;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_all("reset_edge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
        reset_n = 1'b1;
        step();
        #1;
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model; addresses kept narrow to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            set_in($urandom_range(0, 1), 5'($urandom_range(0, lim)), $urandom,
                   $urandom_range(0, 1), 5'($urandom_range(0, lim)), $urandom,
                   5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)),
                   ($urandom_range(0, 3) == 0), 5'($urandom_range(0, lim)));
            #1;
            chk_model($sformatf("rnd%0d", n));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus process ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
